// File: rtl/i2c_scl_timer.sv
// I2C SCL generator: independent low/high phase lengths, slave clock-stretch
// handling with timeout, graceful stop on disable, SDA change/sample strobes.
module i2c_scl_timer #(
  parameter int DIV_W      = 12,
  parameter int TO_W       = 16,
  parameter int STRETCH_EN = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             scl_en,
  input  logic [DIV_W-1:0] cfg_tlow,
  input  logic [DIV_W-1:0] cfg_thigh,
  input  logic             scl_i,
  output logic             scl_o,
  output logic             scl_negedge,
  output logic             scl_posedge,
  output logic             data_chg,
  output logic             data_smp,
  output logic             stretch,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [TO_W-1:0]   tcnt_q;
  logic [DIV_W-1:0]  tl_q;
  logic [DIV_W-1:0]  th_q;
  logic              scl_q;

  logic [DIV_W-1:0]  tl_d;
  logic [DIV_W-1:0]  th_d;
  logic              in_low;
  logic              in_high;
  logic              counted;

  // Phase lengths below 2 are clamped so both midpoints stay distinct from edge strobes
  always_comb begin
    tl_d = (cfg_tlow  < DIV_W'(2)) ? DIV_W'(2) : cfg_tlow;
    th_d = (cfg_thigh < DIV_W'(2)) ? DIV_W'(2) : cfg_thigh;
  end

  // Strobe decode from registered state; once the high phase has started
  // counting (cnt != 0) a low bus level belongs to arbitration, not stretching
  always_comb begin
    in_low      = (state_q == LOW);
    in_high     = (state_q == HIGH);
    counted     = (STRETCH_EN == 0) || scl_i || (cnt_q != '0);
    scl_negedge = in_low && (cnt_q == '0);
    data_chg    = in_low && (cnt_q == (tl_q >> 1));
    scl_posedge = in_high && counted && (cnt_q == '0);
    data_smp    = in_high && counted && (cnt_q == (th_q >> 1));
    timeout     = in_high && !counted && (tcnt_q == '1);
    stretch     = in_high && !counted && (tcnt_q != '1);
    busy        = (state_q != IDLE);
    scl_o       = scl_q;
  end

  // Phase sequencer: IDLE -> LOW -> HIGH -> (LOW | IDLE)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      tl_q    <= '0;
      th_q    <= '0;
      scl_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          scl_q <= 1'b1;
          if (scl_en) begin
            state_q <= LOW;
            scl_q   <= 1'b0;
            cnt_q   <= '0;
            tl_q    <= tl_d;
            th_q    <= th_d;
          end
        end
        LOW: begin
          if (cnt_q == tl_q - DIV_W'(1)) begin
            state_q <= HIGH;
            scl_q   <= 1'b1;
            cnt_q   <= '0;
            tcnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        HIGH: begin
          if (timeout) begin
            state_q <= IDLE;
            scl_q   <= 1'b1;
            cnt_q   <= '0;
            tcnt_q  <= '0;
          end else if (!counted) begin
            tcnt_q <= tcnt_q + TO_W'(1);
          end else if (cnt_q == th_q - DIV_W'(1)) begin
            cnt_q <= '0;
            if (scl_en) begin
              state_q <= LOW;
              scl_q   <= 1'b0;
              tl_q    <= tl_d;
              th_q    <= th_d;
            end else begin
              state_q <= IDLE;
              scl_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          scl_q   <= 1'b1;
          cnt_q   <= '0;
          tcnt_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_timer.sv
// Randomised bench for i2c_scl_timer: two instances (stretch honoured with a
// 4-bit timeout, stretch ignored) against a period-level reference model.
module tb_i2c_scl_timer;

  localparam int DW     = 8;
  localparam int TW     = 4;
  localparam int TO_LIM = (1 << TW) - 1;
  localparam int NCYC   = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          scl_en;
  logic [DW-1:0] cfg_tlow;
  logic [DW-1:0] cfg_thigh;
  logic          hold;
  logic          scl_i_a;
  logic          scl_i_b;
  logic [1:0]    so, ng, ps, dc, ds, st, tmo, bz;

  // Slave stretches by holding the wire low; the wire is wired-AND with our drive
  assign scl_i_a = so[0] & ~hold;

  i2c_scl_timer #(.DIV_W(DW), .TO_W(TW), .STRETCH_EN(1)) u_a (
    .clk(clk), .rstn(rstn), .scl_en(scl_en), .cfg_tlow(cfg_tlow), .cfg_thigh(cfg_thigh),
    .scl_i(scl_i_a), .scl_o(so[0]), .scl_negedge(ng[0]), .scl_posedge(ps[0]),
    .data_chg(dc[0]), .data_smp(ds[0]), .stretch(st[0]), .timeout(tmo[0]), .busy(bz[0])
  );

  i2c_scl_timer #(.DIV_W(DW), .TO_W(TW), .STRETCH_EN(0)) u_b (
    .clk(clk), .rstn(rstn), .scl_en(scl_en), .cfg_tlow(cfg_tlow), .cfg_thigh(cfg_thigh),
    .scl_i(scl_i_b), .scl_o(so[1]), .scl_negedge(ng[1]), .scl_posedge(ps[1]),
    .data_chg(dc[1]), .data_smp(ds[1]), .stretch(st[1]), .timeout(tmo[1]), .busy(bz[1])
  );

  // Reference model: each period is a timeline of tl low cycles, k stretch
  // cycles, th counted high cycles; pos is the cycle index within it.
  bit act[2];
  int pos[2], tl[2], th[2], k[2];

  typedef struct packed {
    int         u;
    logic [7:0] v;   // {scl_o, negedge, posedge, chg, smp, stretch, timeout, busy}
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic int pick_k();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4) return 0;
    if (r <= 6) return $urandom_range(1, 6);
    if (r == 7) return 14 + $urandom_range(0, 2);
    if (r == 8) return 20;
    return $urandom_range(1, 3);
  endfunction

  function automatic logic [7:0] expect_vec(int u);
    logic [7:0] v;
    int kk, c;
    bit tcase;
    if (!act[u]) return 8'b1000_0000;
    tcase = (k[u] > TO_LIM);
    kk = tcase ? TO_LIM : k[u];
    v = 8'b0000_0001;
    if (pos[u] < tl[u]) begin
      v[6] = (pos[u] == 0);
      v[4] = (pos[u] == tl[u] / 2);
    end else if (pos[u] < tl[u] + kk) begin
      v[7] = 1'b1;
      v[2] = 1'b1;
    end else if (tcase) begin
      v[7] = 1'b1;
      v[1] = 1'b1;
    end else begin
      c = pos[u] - tl[u] - kk;
      v[7] = 1'b1;
      v[5] = (c == 0);
      v[3] = (c == th[u] / 2);
    end
    return v;
  endfunction

  task automatic start_period(input int u);
    act[u] = 1'b1;
    pos[u] = 0;
    tl[u]  = (int'(cfg_tlow)  < 2) ? 2 : int'(cfg_tlow);
    th[u]  = (int'(cfg_thigh) < 2) ? 2 : int'(cfg_thigh);
    k[u]   = (u == 0) ? pick_k() : 0;
  endtask

  task automatic advance(input int u);
    if (!rstn) begin
      act[u] = 1'b0;
    end else if (!act[u]) begin
      if (scl_en) start_period(u);
    end else if (k[u] > TO_LIM && pos[u] == tl[u] + TO_LIM) begin
      act[u] = 1'b0;
    end else if (pos[u] == tl[u] + k[u] + th[u] - 1) begin
      if (scl_en) start_period(u);
      else act[u] = 1'b0;
    end else begin
      pos[u]++;
    end
  endtask

  // Slave hold for instance A: held through the planned stretch; random low
  // glitches after counting started model another master and must be ignored
  function automatic logic hold_for_a();
    if (!act[0] || pos[0] < tl[0]) return 1'b0;
    if (pos[0] < tl[0] + k[0]) return 1'b1;
    if (pos[0] > tl[0] + k[0]) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  // Monitor: compare every presented output vector against the queued expectation
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      logic [7:0] a;
      e = sbq.pop_front();
      a = {so[e.u], ng[e.u], ps[e.u], dc[e.u], ds[e.u], st[e.u], tmo[e.u], bz[e.u]};
      n_vec++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL outvec unit%0d t=%0t got=%b exp=%b", e.u, $time, a, e.v);
      end
    end
  end

  initial begin
    int en_prob;
    act[0] = 1'b0; act[1] = 1'b0;
    rstn = 1'b0; scl_en = 1'b0; hold = 1'b0; scl_i_b = 1'b0;
    cfg_tlow = 8'd4; cfg_thigh = 8'd4;
    en_prob = 95;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rstn = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      if (cyc % 64 == 0) en_prob = ($urandom_range(0, 2) == 0) ? 30 : 95;
      scl_en = ($urandom_range(0, 99) < en_prob);
      if ($urandom_range(0, 15) == 0) cfg_tlow  = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) cfg_thigh = 8'($urandom_range(0, 9));
      scl_i_b = 1'($urandom_range(0, 1));
      hold = hold_for_a();
      for (int u = 0; u < 2; u++) sbq.push_back('{u: u, v: expect_vec(u)});
      for (int u = 0; u < 2; u++) advance(u);
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
